// File: rtl/permute_controller.sv
// Moore control FSM for the line permutation datapath.
// Sequences read / next-i calculation / correction / update / write per cell.
module permute_controller #(
    parameter int MAX_CELLS = 25,
    parameter int MAX_FIX   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       done,
    input  logic       sign,
    output logic       ready,
    output logic       finished,
    output logic       error,
    output logic       initLine,
    output logic       IJen,
    output logic       IJregen,
    output logic       read,
    output logic       firstread,
    output logic       writeVal,
    output logic       writeMemReg,
    output logic       isArith,
    output logic       ldTillPositive,
    output logic       waitCalNexti,
    output logic       update,
    output logic       write,
    output logic       ok,
    output logic [4:0] cell_count
);

    localparam int FW = (MAX_FIX < 2) ? 1 : $clog2(MAX_FIX + 1);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] INIT   = 4'd1;
    localparam logic [3:0] READ   = 4'd2;
    localparam logic [3:0] CALC   = 4'd3;
    localparam logic [3:0] FIX    = 4'd4;
    localparam logic [3:0] UPD    = 4'd5;
    localparam logic [3:0] WRITE  = 4'd6;
    localparam logic [3:0] FINISH = 4'd7;
    localparam logic [3:0] ERR    = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [4:0]    cell_q, cell_d, cell_inc;
    logic [FW-1:0] fix_q, fix_d, fix_inc;
    logic          error_q, error_d;

    assign cell_inc = (cell_q == 5'd31) ? cell_q : cell_q + 5'd1;
    assign fix_inc  = fix_q + FW'(1);

    always_comb begin
        state_d = state_q;
        cell_d  = cell_q;
        fix_d   = fix_q;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    error_d = 1'b0;
                end
            end
            INIT: begin
                cell_d  = 5'd0;
                state_d = READ;
            end
            READ: state_d = CALC;
            CALC: begin
                fix_d   = '0;
                state_d = sign ? FIX : UPD;
            end
            FIX: begin
                fix_d = fix_inc;
                if (!sign)
                    state_d = UPD;
                else if (fix_inc == FW'(MAX_FIX))
                    state_d = ERR;
            end
            UPD: state_d = WRITE;
            WRITE: begin
                cell_d = cell_inc;
                // done wins over the cell-limit abort
                if (done)
                    state_d = FINISH;
                else if (cell_inc == 5'(MAX_CELLS))
                    state_d = ERR;
                else
                    state_d = READ;
            end
            FINISH: state_d = IDLE;
            ERR:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == ERR)
            error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cell_q  <= 5'd0;
            fix_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
            fix_q   <= fix_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        ready          = 1'b0;
        finished       = 1'b0;
        initLine       = 1'b0;
        IJen           = 1'b0;
        IJregen        = 1'b0;
        read           = 1'b0;
        firstread      = 1'b0;
        writeVal       = 1'b0;
        writeMemReg    = 1'b0;
        isArith        = 1'b0;
        ldTillPositive = 1'b0;
        waitCalNexti   = 1'b0;
        update         = 1'b0;
        write          = 1'b0;
        ok             = 1'b0;
        unique case (state_q)
            IDLE: ready = 1'b1;
            INIT: begin
                initLine = 1'b1;
                IJen     = 1'b1;
                IJregen  = 1'b1;
            end
            READ: begin
                read        = 1'b1;
                writeVal    = 1'b1;
                writeMemReg = 1'b1;
                firstread   = (cell_q == 5'd0);
            end
            CALC: begin
                isArith        = 1'b1;
                ldTillPositive = 1'b1;
            end
            FIX: begin
                waitCalNexti   = 1'b1;
                ldTillPositive = 1'b1;
            end
            UPD: begin
                update  = 1'b1;
                IJregen = 1'b1;
            end
            WRITE: write = 1'b1;
            FINISH: begin
                finished = 1'b1;
                ok       = 1'b1;
            end
            default: ;
        endcase
    end

    assign error      = error_q;
    assign cell_count = cell_q;

endmodule

// File: tb/tb_permute_controller.sv
// Bench for permute_controller: datapath flag driver plus
// an end-of-run scoreboard (kind, cell count, latency from INIT).
module tb_permute_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic done = 1'b0;
    logic sign = 1'b0;
    logic ready, finished, error, initLine, IJen, IJregen;
    logic read, firstread, writeVal, writeMemReg, isArith;
    logic ldTillPositive, waitCalNexti, update, write, ok;
    logic [4:0] cell_count;

    permute_controller dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .sign(sign), .ready(ready), .finished(finished),
        .error(error), .initLine(initLine), .IJen(IJen),
        .IJregen(IJregen), .read(read), .firstread(firstread),
        .writeVal(writeVal), .writeMemReg(writeMemReg),
        .isArith(isArith), .ldTillPositive(ldTillPositive),
        .waitCalNexti(waitCalNexti), .update(update),
        .write(write), .ok(ok), .cell_count(cell_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        bit fin;
        int cnt;
        int lat;
    } ev_t;
    ev_t sbq[$];

    // datapath flag model
    int done_at = 0;
    int fix_ones = 0;
    int wcnt = 0;
    int fseen = 0;

    initial forever begin
        @(negedge clk);
        if (initLine) wcnt = 0;
        if (isArith) begin
            fseen = 0;
            sign = (wcnt == 0 && fix_ones > 0);
        end else if (waitCalNexti) begin
            fseen++;
            sign = (fseen <= fix_ones);
        end else begin
            sign = 1'b0;
        end
        if (write) begin
            wcnt++;
            done = (wcnt == done_at);
        end else begin
            done = 1'b0;
        end
    end

    // monitor
    int cyc = 0;
    int lat = 0;
    int wcn = 0;
    int rd_cyc = 0;
    int cell_len = 0;
    logic err_q = 1'b0;
    ev_t ev;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            lat = 0;
            err_q = 1'b0;
        end else begin
            if (initLine) begin
                lat = 1;
                wcn = 0;
            end else if (lat != 0) begin
                lat++;
            end
            if (waitCalNexti) wcn++;
            if (read) rd_cyc = cyc;
            if (write) cell_len = cyc - rd_cyc + 1;
            chk("rw_excl", 32'(read & write), 0);
            if (finished) chk("ok_with_fin", 32'(ok), 1);
            if (finished || (error && !err_q)) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_evt", 32'(finished), 32'hdead);
                end else begin
                    ev = sbq.pop_front();
                    chk("evt_kind", 32'(finished), 32'(ev.fin));
                    chk("evt_cnt", 32'(cell_count), ev.cnt);
                    chk("evt_lat", lat, ev.lat);
                end
            end
            err_q = error;
        end
    end

    task automatic push(input bit fin, input int cnt, input int l);
        ev_t e;
        e.fin = fin;
        e.cnt = cnt;
        e.lat = l;
        sbq.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("back_idle", 32'(ready), 1);
    endtask

    initial begin
        int n;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_read", 32'(read), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_fin", 32'(finished), 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_cnt", 32'(cell_count), 0);
        chk("rst_init", 32'(initLine), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 1);

        // cell-limit abort
        done_at = 0;
        fix_ones = 0;
        push(0, 25, 102);
        do_start();
        chk("busy_ready", 32'(ready), 0);
        chk("init_line", 32'(initLine), 1);
        chk("init_ij", 32'(IJen & IJregen), 1);
        wait_drain(200);
        wait_ready(5);
        chk("abort_err", 32'(error), 1);
        chk("abort_cnt", 32'(cell_count), 25);

        // done on third write
        done_at = 3;
        push(1, 3, 14);
        do_start();
        chk("err_clr", 32'(error), 0);
        wait_drain(50);
        wait_ready(5);
        chk("fin_cnt_hold", 32'(cell_count), 3);

        // two corrections then positive
        done_at = 1;
        fix_ones = 2;
        push(1, 1, 9);
        do_start();
        wait_drain(50);
        wait_ready(5);
        chk("fix_cycles", wcn, 3);
        chk("cell_len", cell_len, 7);

        // sign stuck high
        done_at = 0;
        fix_ones = 99;
        push(0, 0, 8);
        do_start();
        wait_drain(50);
        wait_ready(5);
        chk("stuck_fix", wcn, 4);
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(error), 1);

        // reset during FIX
        do_start();
        chk("err_clr2", 32'(error), 0);
        n = 0;
        while (!waitCalNexti && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fix_reached", 32'(waitCalNexti), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_fix", 32'(waitCalNexti), 0);
        chk("mid_rst_ld", 32'(ldTillPositive), 0);
        chk("mid_rst_cnt", 32'(cell_count), 0);
        chk("mid_rst_err", 32'(error), 0);
        @(negedge clk);
        rst = 1'b1;
        fix_ones = 0;
        done_at = 1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 1);
        push(1, 1, 6);
        do_start();
        n = 0;
        while (!read && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("first_read", 32'(firstread), 1);
        wait_drain(50);
        wait_ready(5);

        // start ignored during WRITE
        done_at = 5;
        push(1, 5, 22);
        do_start();
        n = 0;
        while (!(write && cell_count == 5'd1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("write2_seen", 32'(write), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ign_init", 32'(initLine), 0);
        chk("start_ign_cnt", 32'(cell_count), 2);
        n = 0;
        while (!read && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("no_firstread", 32'(firstread), 0);
        wait_drain(60);
        wait_ready(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/permute_controller.md
PERMUTE_CONTROLLER -- requirements
Module: permute_controller

Interface
REQ-001 The block SHALL have parameter MAX_CELLS, default 25, meaning the number of cell writes allowed before an abort.
REQ-002 The block SHALL have parameter MAX_FIX, default 4, meaning the number of add-5 correction cycles allowed per cell.
REQ-003 The block SHALL have port clk  input  1  clock, all state updated on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to permute the loaded line.
REQ-006 The block SHALL have port done  input  1  datapath flag, current i/j registers equal (3,3).
REQ-007 The block SHALL have port sign  input  1  datapath flag, next-i intermediate value is negative.
REQ-008 The block SHALL have port ready  output  1  idle, start accepted.
REQ-009 The block SHALL have port finished  output  1  one-cycle pulse, permutation complete.
REQ-010 The block SHALL have port error  output  1  sticky abort flag, cleared by next accepted start.
REQ-011 The block SHALL have port initLine  output  1  load the input line into memory.
REQ-012 The block SHALL have port IJen  output  1  force i=j=3.
REQ-013 The block SHALL have port IJregen  output  1  load i/j registers.
REQ-014 The block SHALL have port read  output  1  memory read of the current cell.
REQ-015 The block SHALL have port firstread  output  1  qualifies the first read of a run.
REQ-016 The block SHALL have port writeVal  output  1  latch the read bit.
REQ-017 The block SHALL have port writeMemReg  output  1  latch the current memory index.
REQ-018 The block SHALL have port isArith  output  1  enable the next-i subtractor.
REQ-019 The block SHALL have port ldTillPositive  output  1  load the next-i register.
REQ-020 The block SHALL have port waitCalNexti  output  1  select the add-5 path.
REQ-021 The block SHALL have port update  output  1  advance i/j to the next coordinates.
REQ-022 The block SHALL have port write  output  1  write the latched bit at the latched index.
REQ-023 The block SHALL have port ok  output  1  commit memory, asserted with finished.
REQ-024 The block SHALL have port cell_count  output  5  cells written in the current run.

Function
REQ-025 The block SHALL use the states IDLE, INIT, READ, CALC, FIX, UPD, WRITE, FINISH and ERR, and all outputs SHALL be Moore-decoded from the state register.
REQ-026 In IDLE the block SHALL assert ready, and start SHALL move it to INIT and clear error; start in any other state SHALL be ignored.
REQ-027 In INIT the block SHALL assert initLine, IJen and IJregen, clear cell_count, then move unconditionally to READ.
REQ-028 In READ the block SHALL assert read, writeVal and writeMemReg, plus firstread only when cell_count=0, then move to CALC.
REQ-029 In CALC the block SHALL assert isArith and ldTillPositive, then move to FIX if sign=1, else to UPD.
REQ-030 In FIX the block SHALL assert waitCalNexti and ldTillPositive, and increment an internal fix counter (cleared in CALC).
REQ-031 FIX SHALL move to UPD when sign=0, to ERR when sign=1 and the fix counter has reached MAX_FIX, and SHALL otherwise stay in FIX.
REQ-032 In UPD the block SHALL assert update and IJregen, then move to WRITE.
REQ-033 In WRITE the block SHALL assert write and increment cell_count (saturating at 31).
REQ-034 From WRITE the block SHALL move to FINISH if done=1, to ERR if done=0 and the incremented count equals MAX_CELLS, and to READ otherwise.
REQ-035 In FINISH the block SHALL assert finished and ok for exactly one cycle, then move to IDLE; cell_count SHALL hold its value until the next INIT.
REQ-036 In ERR the block SHALL set error, drive all datapath strobes low, and move to IDLE the next cycle.
REQ-037 Per-cell latency SHALL be 4 cycles plus the number of FIX cycles, and INIT SHALL add 1 cycle per run.
REQ-038 When done and the abort condition coincide in WRITE, done SHALL take priority.
REQ-039 Exactly one of read or write SHALL be high in any cycle, or neither.

Reset
REQ-040 rst=0 SHALL asynchronously force state IDLE, cell_count=0, the fix counter=0 and error=0, with all strobes low and ready=1 one cycle after release.
REQ-041 Reset asserted mid-run SHALL abandon the run with no finished pulse, and a subsequent start SHALL begin a fresh INIT.

Verification
REQ-042 Reset then start with done held 0 and sign 0: the bench SHALL see ready=0, INIT, then READ/CALC/UPD/WRITE loops; after 25 writes, error=1, finished never asserts, and the block returns to IDLE.
REQ-043 Start with sign 0 and done=1 on the 3rd WRITE: the bench SHALL see finished=1 exactly 14 cycles after INIT and cell_count=3.
REQ-044 sign=1 for 2 FIX cycles then 0: the bench SHALL see waitCalNexti high for 3 cycles and the cell take 7 cycles.
REQ-045 sign stuck at 1: the bench SHALL see ERR after 4 FIX cycles and error=1 until the next start.
REQ-046 rst pulsed low during FIX: the bench SHALL see outputs go to reset values immediately, and a new start SHALL produce firstread=1 on the first READ.
REQ-047 Start pulsed during WRITE: the bench SHALL see no effect and cell_count continue counting.
